// File: rtl/step_dir_monitor.sv
// Receive-side step/dir monitor: decodes synchronized step pulses into position and
// step count, measures step period and checks dir setup, pulse width and low gap timing.
module step_dir_monitor #(
  parameter int POS_WIDTH = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 step,
  input  logic                 dir,
  input  logic                 invert_dir,
  input  logic [CNT_WIDTH-1:0] dir_setup_n,
  input  logic [CNT_WIDTH-1:0] pulse_min_n,
  input  logic [CNT_WIDTH-1:0] gap_min_n,
  input  logic                 load_pos,
  input  logic [POS_WIDTH-1:0] pos_val,
  input  logic                 clear_err,
  output logic [POS_WIDTH-1:0] position,
  output logic [31:0]          step_count,
  output logic [CNT_WIDTH-1:0] last_period,
  output logic                 period_valid,
  output logic                 step_stb,
  output logic                 step_dir_out,
  output logic [3:0]           err,
  output logic                 err_int
);

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_ONES = {CNT_WIDTH{1'b1}};
  localparam logic [POS_WIDTH-1:0] POS_ONE  = {{(POS_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [POS_WIDTH-1:0] POS_ONES = {POS_WIDTH{1'b1}};

  typedef enum logic [0:0] {
    ST_LOW  = 1'b0,
    ST_HIGH = 1'b1
  } state_t;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (v == CNT_ONES) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_ONE;
    end
  endfunction

  logic step_s1_r, step_s2_r, step_s3_r;
  logic dir_s1_r, dir_s2_r, dir_s3_r;
  logic rise_s, fall_s, dchg_s;

  state_t state_r, state_next_s;
  logic   in_low_s, in_high_s;

  logic [CNT_WIDTH-1:0] low_cnt_r, high_cnt_r, dir_cnt_r, period_cnt_r;

  logic [POS_WIDTH-1:0] position_r, pos_delta_s;
  logic [31:0]          step_count_r;
  logic [CNT_WIDTH-1:0] last_period_r;
  logic                 period_valid_r, seen_rise_r, step_stb_r, step_dir_r, step_dir_s;
  logic [3:0]           err_r, err_set_s;
  logic                 err_int_r;
  logic                 setup_bad_s, gap_bad_s, pulse_bad_s;

  // Two-flop synchronizers plus a third stage for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      step_s1_r <= 1'b0;
      step_s2_r <= 1'b0;
      step_s3_r <= 1'b0;
      dir_s1_r  <= 1'b0;
      dir_s2_r  <= 1'b0;
      dir_s3_r  <= 1'b0;
    end else begin
      step_s1_r <= step;
      step_s2_r <= step_s1_r;
      step_s3_r <= step_s2_r;
      dir_s1_r  <= dir;
      dir_s2_r  <= dir_s1_r;
      dir_s3_r  <= dir_s2_r;
    end
  end

  assign rise_s = step_s2_r & ~step_s3_r;
  assign fall_s = ~step_s2_r & step_s3_r;
  assign dchg_s = dir_s2_r ^ dir_s3_r;

  // Pulse-level FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_LOW;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Pulse-level FSM next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_LOW:  state_next_s = rise_s ? ST_HIGH : ST_LOW;
      ST_HIGH: state_next_s = fall_s ? ST_LOW : ST_HIGH;
      default: state_next_s = ST_LOW;
    endcase
  end

  // Pulse-level FSM state decode
  always_comb begin
    in_low_s  = 1'b0;
    in_high_s = 1'b0;
    case (state_r)
      ST_LOW:  in_low_s  = 1'b1;
      ST_HIGH: in_high_s = 1'b1;
      default: in_low_s  = 1'b1;
    endcase
  end

  // Saturating timing counters; low/dir reset to all-ones so the first pulse is clean
  always_ff @(posedge clk) begin
    if (rst) begin
      low_cnt_r    <= CNT_ONES;
      high_cnt_r   <= CNT_ZERO;
      dir_cnt_r    <= CNT_ONES;
      period_cnt_r <= CNT_ZERO;
    end else begin
      if (in_low_s) begin
        low_cnt_r <= sat_inc(low_cnt_r);
        if (rise_s) begin
          high_cnt_r <= CNT_ONE;
        end
      end else if (in_high_s) begin
        high_cnt_r <= sat_inc(high_cnt_r);
        if (fall_s) begin
          low_cnt_r <= CNT_ONE;
        end
      end
      dir_cnt_r    <= dchg_s ? CNT_ZERO : sat_inc(dir_cnt_r);
      period_cnt_r <= rise_s ? CNT_ONE : sat_inc(period_cnt_r);
    end
  end

  assign step_dir_s  = dir_s2_r ^ invert_dir;
  assign pos_delta_s = step_dir_s ? POS_ONE : POS_ONES;

  // A zero limit disables its check entirely
  assign setup_bad_s = (dir_setup_n != CNT_ZERO) && ((dir_cnt_r < dir_setup_n) || dchg_s);
  assign gap_bad_s   = (gap_min_n != CNT_ZERO) && (low_cnt_r < gap_min_n);
  assign pulse_bad_s = (pulse_min_n != CNT_ZERO) && (high_cnt_r < pulse_min_n);
  assign err_set_s   = {in_high_s & dchg_s, rise_s & gap_bad_s,
                        fall_s & pulse_bad_s, rise_s & setup_bad_s};

  // Step decode: position, count, period and strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      position_r     <= {POS_WIDTH{1'b0}};
      step_count_r   <= 32'd0;
      last_period_r  <= CNT_ZERO;
      period_valid_r <= 1'b0;
      seen_rise_r    <= 1'b0;
      step_stb_r     <= 1'b0;
      step_dir_r     <= 1'b0;
    end else begin
      step_stb_r <= rise_s;
      if (rise_s) begin
        step_dir_r     <= step_dir_s;
        step_count_r   <= step_count_r + 32'd1;
        last_period_r  <= period_cnt_r;
        period_valid_r <= period_valid_r | seen_rise_r;
        seen_rise_r    <= 1'b1;
      end
      if (load_pos) begin
        position_r <= rise_s ? (pos_val + pos_delta_s) : pos_val;
      end else if (rise_s) begin
        position_r <= position_r + pos_delta_s;
      end
    end
  end

  // Sticky error flags; a set condition beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r     <= 4'b0000;
      err_int_r <= 1'b0;
    end else begin
      err_r     <= (clear_err ? 4'b0000 : err_r) | err_set_s;
      err_int_r <= |err_r;
    end
  end

  assign position     = position_r;
  assign step_count   = step_count_r;
  assign last_period  = last_period_r;
  assign period_valid = period_valid_r;
  assign step_stb     = step_stb_r;
  assign step_dir_out = step_dir_r;
  assign err          = err_r;
  assign err_int      = err_int_r;

endmodule

// File: tb/tb_step_dir_monitor.sv
// Directed self-checking bench for step_dir_monitor: one task per scenario,
// each with inline comparisons against hand-computed values.
module tb_step_dir_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        step;
  logic        dir;
  logic        invert_dir;
  logic [31:0] dir_setup_n;
  logic [31:0] pulse_min_n;
  logic [31:0] gap_min_n;
  logic        load_pos;
  logic [31:0] pos_val;
  logic        clear_err;
  logic [31:0] position;
  logic [31:0] step_count;
  logic [31:0] last_period;
  logic        period_valid;
  logic        step_stb;
  logic        step_dir_out;
  logic [3:0]  err;
  logic        err_int;

  int checks   = 0;
  int failures = 0;
  int stb_total = 0;
  int stb_wide  = 0;
  logic stb_prev = 1'b0;

  step_dir_monitor #(.POS_WIDTH(32), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .step(step), .dir(dir), .invert_dir(invert_dir),
    .dir_setup_n(dir_setup_n), .pulse_min_n(pulse_min_n), .gap_min_n(gap_min_n),
    .load_pos(load_pos), .pos_val(pos_val), .clear_err(clear_err),
    .position(position), .step_count(step_count), .last_period(last_period),
    .period_valid(period_valid), .step_stb(step_stb), .step_dir_out(step_dir_out),
    .err(err), .err_int(err_int)
  );

  always #5 clk = ~clk;

  // Count strobe pulses and any strobe lasting more than one cycle
  always @(negedge clk) begin
    if (step_stb) stb_total <= stb_total + 1;
    if (step_stb && stb_prev) stb_wide <= stb_wide + 1;
    stb_prev <= step_stb;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int high, input int low);
    step = 1'b1;
    cyc(high);
    step = 1'b0;
    cyc(low);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step = 1'b0;
    load_pos = 1'b0;
    clear_err = 1'b0;
    cyc(3);
    rst = 1'b0;
    cyc(10);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step = 1'b0;
    dir = 1'b1;
    invert_dir = 1'b0;
    dir_setup_n = 32'd4;
    pulse_min_n = 32'd4;
    gap_min_n = 32'd4;
    load_pos = 1'b0;
    pos_val = 32'd0;
    clear_err = 1'b0;
    cyc(3);
    checks++; if (position !== 32'd0) begin failures++; $display("FAIL rst_position got=%0h exp=0", position); end
    checks++; if (step_count !== 32'd0) begin failures++; $display("FAIL rst_step_count got=%0d exp=0", step_count); end
    checks++; if ({last_period, period_valid, step_stb, step_dir_out} !== 35'd0) begin
      failures++; $display("FAIL rst_misc last_period=%0d valid=%b stb=%b dir=%b exp all 0", last_period, period_valid, step_stb, step_dir_out); end
    checks++; if ({err, err_int} !== 5'b00000) begin failures++; $display("FAIL rst_err got=%b/%b exp=0000/0", err, err_int); end
    rst = 1'b0;
    cyc(10);
  endtask

  task automatic test_forward_steps();
    int base;
    int wbase;
    base = stb_total;
    wbase = stb_wide;
    for (int i = 0; i < 5; i++) pulse(10, 20);
    checks++; if (position !== 32'd5) begin failures++; $display("FAIL fwd_position got=%0d exp=5", position); end
    checks++; if (step_count !== 32'd5) begin failures++; $display("FAIL fwd_step_count got=%0d exp=5", step_count); end
    checks++; if (last_period !== 32'd30) begin failures++; $display("FAIL fwd_last_period got=%0d exp=30", last_period); end
    checks++; if (period_valid !== 1'b1) begin failures++; $display("FAIL fwd_period_valid got=%b exp=1", period_valid); end
    checks++; if ({err, err_int} !== 5'b00000) begin failures++; $display("FAIL fwd_err got=%b/%b exp=0000/0", err, err_int); end
    checks++; if (stb_total - base !== 5) begin failures++; $display("FAIL fwd_stb_count got=%0d exp=5", stb_total - base); end
    checks++; if (stb_wide - wbase !== 0) begin failures++; $display("FAIL fwd_stb_width wide=%0d exp=0", stb_wide - wbase); end
    checks++; if (step_dir_out !== 1'b1) begin failures++; $display("FAIL fwd_dir got=%b exp=1", step_dir_out); end
  endtask

  task automatic test_inverted_dir();
    invert_dir = 1'b1;
    dir = 1'b1;
    apply_reset();
    for (int i = 0; i < 3; i++) pulse(10, 20);
    checks++; if (position !== 32'hFFFF_FFFD) begin failures++; $display("FAIL inv_position got=%0h exp=fffffffd", position); end
    checks++; if (step_dir_out !== 1'b0) begin failures++; $display("FAIL inv_dir got=%b exp=0", step_dir_out); end
    checks++; if (step_count !== 32'd3) begin failures++; $display("FAIL inv_step_count got=%0d exp=3", step_count); end
    invert_dir = 1'b0;
  endtask

  task automatic test_setup_error();
    dir = 1'b0;
    dir_setup_n = 32'd5;
    pulse_min_n = 32'd0;
    gap_min_n = 32'd0;
    apply_reset();
    dir = 1'b1;
    cyc(2);
    step = 1'b1;
    cyc(3);
    checks++; if (err !== 4'b0001) begin failures++; $display("FAIL setup_err got=%b exp=0001", err); end
    checks++; if (err_int !== 1'b0) begin failures++; $display("FAIL setup_int_early got=%b exp=0", err_int); end
    cyc(1);
    checks++; if (err_int !== 1'b1) begin failures++; $display("FAIL setup_int got=%b exp=1", err_int); end
    cyc(5);
    step = 1'b0;
    cyc(10);
    clear_err = 1'b1;
    cyc(1);
    clear_err = 1'b0;
    checks++; if (err !== 4'b0000) begin failures++; $display("FAIL setup_clear got=%b exp=0000", err); end
    cyc(1);
    checks++; if (err_int !== 1'b0) begin failures++; $display("FAIL setup_clear_int got=%b exp=0", err_int); end
  endtask

  task automatic test_pulse_gap_dir_errors();
    dir = 1'b1;
    dir_setup_n = 32'd0;
    pulse_min_n = 32'd4;
    gap_min_n = 32'd3;
    apply_reset();
    pulse(3, 10);
    checks++; if (err !== 4'b0010) begin failures++; $display("FAIL pulse_err got=%b exp=0010", err); end
    checks++; if (err_int !== 1'b1) begin failures++; $display("FAIL pulse_int got=%b exp=1", err_int); end
    clear_err = 1'b1;
    cyc(1);
    clear_err = 1'b0;
    pulse(5, 2);
    step = 1'b1;
    cyc(3);
    dir = 1'b0;
    cyc(5);
    step = 1'b0;
    cyc(10);
    checks++; if (err !== 4'b1100) begin failures++; $display("FAIL gap_dir_err got=%b exp=1100", err); end
    checks++; if (position !== 32'd3) begin failures++; $display("FAIL gap_position got=%0d exp=3", position); end
  endtask

  task automatic test_load_wrap();
    dir = 1'b1;
    dir_setup_n = 32'd0;
    pulse_min_n = 32'd0;
    gap_min_n = 32'd0;
    apply_reset();
    load_pos = 1'b1;
    pos_val = 32'h0000_0100;
    cyc(1);
    load_pos = 1'b0;
    checks++; if (position !== 32'h0000_0100) begin failures++; $display("FAIL load_plain got=%0h exp=100", position); end
    step = 1'b1;
    cyc(2);
    load_pos = 1'b1;
    pos_val = 32'h7FFF_FFFF;
    cyc(1);
    load_pos = 1'b0;
    checks++; if (position !== 32'h8000_0000) begin failures++; $display("FAIL load_wrap got=%0h exp=80000000", position); end
    checks++; if (step_stb !== 1'b1) begin failures++; $display("FAIL load_stb got=%b exp=1", step_stb); end
    step = 1'b0;
    cyc(10);
  endtask

  task automatic test_reset_mid_pulse();
    dir = 1'b1;
    apply_reset();
    step = 1'b1;
    cyc(5);
    checks++; if (position !== 32'd1) begin failures++; $display("FAIL mid_pre_position got=%0d exp=1", position); end
    rst = 1'b1;
    cyc(2);
    checks++; if ({position, step_count} !== 64'd0) begin failures++; $display("FAIL mid_rst_counts pos=%0d cnt=%0d exp 0/0", position, step_count); end
    checks++; if ({err, err_int, period_valid, step_stb, step_dir_out} !== 8'd0) begin
      failures++; $display("FAIL mid_rst_flags err=%b int=%b valid=%b stb=%b dir=%b exp all 0", err, err_int, period_valid, step_stb, step_dir_out); end
    rst = 1'b0;
    cyc(2);
    checks++; if (position !== 32'd0) begin failures++; $display("FAIL mid_early_position got=%0d exp=0", position); end
    cyc(1);
    checks++; if (position !== 32'd1) begin failures++; $display("FAIL mid_position got=%0d exp=1", position); end
    checks++; if (step_count !== 32'd1) begin failures++; $display("FAIL mid_step_count got=%0d exp=1", step_count); end
    checks++; if (step_stb !== 1'b1) begin failures++; $display("FAIL mid_stb got=%b exp=1", step_stb); end
    step = 1'b0;
    cyc(10);
  endtask

  initial begin
    test_reset();
    test_forward_steps();
    test_inverted_dir();
    test_setup_error();
    test_pulse_gap_dir_errors();
    test_load_wrap();
    test_reset_mid_pulse();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/step_dir_monitor.md
Name: step_dir_monitor

Overview:
- Receive-side counterpart of the motor step/dir generator. Samples a step/dir pin pair, the same signals the generator drives to the stepper driver.
- Decodes each step pulse into a signed position update and a step count.
- Measures inter-step period.
- Checks pulse timing against programmable minimums: dir setup, pulse high width, low gap.
- Raises sticky error flags.
- Sits beside each axis so the executor can read actual position and timing health through in_regs and an interrupt line.

Parameters:
- POS_WIDTH, 32, width of signed position and load value.
- CNT_WIDTH, 32, width of timing counters, timing limits and last_period.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- step  input  1  step pin (asynchronous to clk)
- dir  input  1  dir pin (asynchronous to clk)
- invert_dir  input  1  1: dir=0 means +1 step
- dir_setup_n  input  CNT_WIDTH  min cycles dir stable before step rise
- pulse_min_n  input  CNT_WIDTH  min step high cycles
- gap_min_n  input  CNT_WIDTH  min step low cycles before next rise
- load_pos  input  1  strobe: load position from pos_val
- pos_val  input  POS_WIDTH  position load value
- clear_err  input  1  strobe: clear sticky errors
- position  output  POS_WIDTH  signed decoded position
- step_count  output  32  total rising edges seen
- last_period  output  CNT_WIDTH  cycles between last two rises
- period_valid  output  1  last_period holds a real measurement
- step_stb  output  1  one-cycle pulse per decoded step
- step_dir_out  output  1  direction of last step (1 = +)
- err  output  4  sticky {dir_hold, gap, pulse, setup}
- err_int  output  1  OR of err bits

Behaviour:
- Synchronizer: step and dir each pass through 2 flops (s1, s2), plus a third flop s3 for edge detect. rise = s2 & ~s3; fall = ~s2 & s3; dchg = dir_s2 ^ dir_s3. Latency: step first sampled high at edge k; the registered outputs update at edge k+2 and are visible after that edge.
- FSM, 2 states:
  - LOW: low_cnt increments (saturating). rise -> HIGH, high_cnt <= 1.
  - HIGH: high_cnt increments (saturating). fall -> LOW, low_cnt <= 1.
  - Reset -> LOW.
- dir_cnt: cleared to 0 on dchg; otherwise increments, saturating at all-ones.
- period_cnt: increments every cycle, saturating.
- On rise:
  - step_stb=1.
  - step_dir_out = dir_s2 ^ invert_dir.
  - position += (+1 if step_dir_out else -1), two's-complement wrap.
  - step_count += 1, wraps.
  - last_period <= period_cnt and period_cnt <= 1. period_valid <= 1 only from the second rise after reset onward.
  - err[0] sets if dir_cnt < dir_setup_n, or if dchg occurs in the same cycle.
  - err[2] sets if low_cnt < gap_min_n.
- On fall: err[1] sets if high_cnt < pulse_min_n.
- In HIGH, any dchg sets err[3].
- load_pos: position <= pos_val. If a rise occurs in the same cycle, position <= pos_val ± 1 (the step applies on top of the load).
- clear_err zeroes err. A set condition in the same cycle wins for that bit.
- A limit of 0 disables its check.
- Reset values:
  - position=0, step_count=0, last_period=0, period_valid=0, step_stb=0, step_dir_out=0, err=0, err_int=0.
  - period_cnt=0, high_cnt=0.
  - low_cnt and dir_cnt = all-ones, so the first pulse after reset never flags setup or gap.
  - Synchronizer flops = 0.
- Reset mid-pulse: FSM -> LOW, and the pin's later fall is ignored (s3=0). If step is still high at reset release, it is seen as a rise 2 cycles later and counts as a step.
- err_int is registered: err_int = |err, one cycle after err updates.

Test Plan:
- Reset, dir=1, then 5 pulses (high 10, low 20 cycles), limits 4/4/4 -> position=5, step_count=5, last_period=30, period_valid=1, err=0, five step_stb pulses each 1 cycle wide.
- invert_dir=1, dir=1, 3 pulses -> position=-3 (0xFFFFFFFD), step_dir_out=0.
- dir toggled 2 cycles before rise with dir_setup_n=5 -> err[0]=1, err_int=1 one cycle later; clear_err -> err=0.
- Pulse high 3 cycles with pulse_min_n=4 -> err[1]; next rise after 2 low cycles with gap_min_n=3 -> err[2]; dir change while high -> err[3].
- load_pos with pos_val=0x7FFFFFFF coincident with a rise, dir=+ -> position=0x80000000 (wrap).
- rst asserted mid-high pulse with step held high -> all outputs 0; after release, position=1 and step_count=1 three edges later.
